pool2x2_stream_ctrl: RTL and testbench



---
 rtl/pool2x2_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_pool2x2_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream_ctrl.sv
// pool2x2_stream_ctrl
// Streaming 2x2 stride-2 max pooling sequencer. Takes an IMG_H x IMG_W
// row-major pixel stream and emits the (IMG_H/2) x (IMG_W/2) pooled map,
// also row-major. A half-row line buffer carries the pairwise maxima of each
// even row into the following odd row.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               frame start pulse (only acted on while idle)
//   in_valid/in_ready   input pixel handshake, in_data = pixel (unsigned)
//   out_valid/out_ready output handshake, out_data = pooled maximum
//   busy                frame in progress
//   done                one-cycle pulse after the last pooled result is taken
module pool2x2_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LBN = IMG_W / 2;
  localparam int KW  = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] h_p0;
  logic [DATA_W-1:0] lb_p0 [LBN];

  logic accept;
  logic out_take;
  logic row_odd;
  logic col_odd;
  logic win_done;

  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // The input only stalls when the single output slot is full and not draining.
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_take = out_valid && out_ready;
  assign row_odd  = row[0];
  assign col_odd  = col[0];
  assign win_done = accept && row_odd && col_odd;
  assign k        = KW'(col >> 1);
  assign busy     = (state == S_RUN) || (state == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= S_WAIT;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_WAIT: begin
          // The last result is in the slot; its handshake ends the frame.
          if (out_take) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A completed window reloads the slot even in a handshake cycle.
      if (win_done) begin
        out_valid <= 1'b1;
        out_data  <= max_u(h_p0, in_data);
      end else if (out_take) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Window accumulation: h_p0 holds the left-column partial of the current
  // pair, lb_p0 carries even-row pair maxima down to the odd row.
  always_ff @(posedge clk) begin
    if (accept && !col_odd) begin
      h_p0 <= row_odd ? max_u(lb_p0[k], in_data) : in_data;
    end
    if (accept && !row_odd && col_odd) begin
      lb_p0[k] <= max_u(h_p0, in_data);
    end
  end

endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// Testbench for pool2x2_stream_ctrl: directed and randomized frames, with a
// queue scoreboard fed from a window-max reference model and a separate
// output monitor.
module tb_pool2x2_stream_ctrl;

  localparam int DW  = 32;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int NPX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  pool2x2_stream_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] px [NPX];
  logic [DW-1:0] exp_q [$];

  int   rmode = 0;        // 0: ready high, 1: random, 2: manual
  logic man_ready = 1'b1;

  int done_cnt = 0, done_cyc = 0, hs_cnt = 0, last_hs_cyc = 0, start_cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference: max over each non-overlapping 2x2 window, row-major order.
  task automatic push_expected();
    for (int r = 0; r < H; r += 2)
      for (int c = 0; c < W; c += 2)
        exp_q.push_back(mx(mx(px[r*W+c], px[r*W+c+1]), mx(px[(r+1)*W+c], px[(r+1)*W+c+1])));
  endtask

  // out_ready driver
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : man_ready;
  end

  // Output monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall keeps out_valid", 32'(out_valid), 32'd1);
        check("stall keeps out_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected output: got 0x%08h expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic begin_frame();
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit gaps, input bit spur);
    int idx = 0;
    int budget = 0;
    bit sent = 1'b0;
    bit acc;
    while (idx < n && budget < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? px[idx] : $urandom;
      start    = spur && (idx == 5) && !sent;
      if (start) sent = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (idx < n) check("pixel drive timeout", 32'(idx), 32'(n));
  endtask

  task automatic wait_done(input int d0);
    int b = 0;
    while (done_cnt == d0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (done_cnt == d0) check("done timeout", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic finish_checks(input string tag, input int d0, input int h0);
    @(negedge clk);
    check({tag, " busy low after done"}, 32'(busy), 32'd0);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " output count"}, 32'(hs_cnt - h0), 32'((W/2)*(H/2)));
    check({tag, " done once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit spur);
    int d0 = done_cnt;
    int h0 = hs_cnt;
    push_expected();
    begin_frame();
    drive_pixels(NPX, gaps, spur);
    wait_done(d0);
    finish_checks(tag, d0, h0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPX; i++) px[i] = DW'(i);
  endtask

  initial begin
    int d0, h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame with timing
    rmode = 0;
    load_ramp();
    run_frame("ramp", 1'b0, 1'b0);
    check("ramp start to last result", 32'(last_hs_cyc - start_cyc), 32'd17);
    check("ramp done after last output", 32'(done_cyc), 32'(last_hs_cyc + 1));

    // Alternating rows
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        px[r*W+c] = (r % 2 == 0) ? DW'(c + 1) : DW'(W - c);
    run_frame("alternating", 1'b0, 1'b0);

    // Backpressure on the first result
    load_ramp();
    rmode = 2;
    man_ready = 1'b0;
    d0 = done_cnt;
    h0 = hs_cnt;
    push_expected();
    begin_frame();
    fork
      drive_pixels(NPX, 1'b0, 1'b0);
      begin
        int b = 0;
        @(negedge clk);
        while (!out_valid && b < 100) begin
          @(negedge clk);
          b++;
        end
        if (!out_valid) begin
          check("bp first result timeout", 32'(out_valid), 32'd1);
        end else begin
          for (int i = 0; i < 3; i++) begin
            check("bp out_data held", out_data, 32'd5);
            check("bp in_ready low", 32'(in_ready), 32'd0);
            if (i < 2) @(negedge clk);
          end
        end
        man_ready = 1'b1;
      end
    join
    wait_done(d0);
    finish_checks("backpressure", d0, h0);

    // Unsigned extremes, random ready
    rmode = 1;
    for (int i = 0; i < NPX; i++) px[i] = $urandom;
    px[0] = 32'hFFFF_FFFF; px[1] = 32'h0;         px[4] = 32'h0; px[5] = 32'h0;
    px[2] = 32'h8000_0000; px[3] = 32'h7FFF_FFFF; px[6] = 32'h1; px[7] = 32'h0;
    run_frame("extremes", 1'b1, 1'b0);

    // Gaps and spurious start
    load_ramp();
    run_frame("ramp gaps", 1'b1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPX; i++) px[i] = $urandom;
      run_frame("random", 1'b1, 1'b1);
    end

    // Reset mid-frame
    rmode = 0;
    load_ramp();
    d0 = done_cnt;
    begin_frame();
    drive_pixels(6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out_data", out_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort no done pulse", 32'(done_cnt), 32'(d0));
    check("abort idle", 32'(busy), 32'd0);
    run_frame("after abort", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
